// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the MEM stage and data memory.
// master = requester (pipeline), slave = memory; ports ce/stb/we/addr/wdata/sel, ack/err/rdata/stall.
interface dmem_responder_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) ();

    logic                dm_i_ce;
    logic                dm_i_stb;
    logic                dm_i_we;
    logic [AWIDTH-1:0]   dm_i_addr;
    logic [DWIDTH-1:0]   dm_i_wdata;
    logic [DWIDTH/8-1:0] dm_i_sel;
    logic                dm_o_ack;
    logic                dm_o_err;
    logic [DWIDTH-1:0]   dm_o_rdata;
    logic                dm_o_stall;

    modport master (
        output dm_i_ce,
        output dm_i_stb,
        output dm_i_we,
        output dm_i_addr,
        output dm_i_wdata,
        output dm_i_sel,
        input  dm_o_ack,
        input  dm_o_err,
        input  dm_o_rdata,
        input  dm_o_stall
    );

    modport slave (
        input  dm_i_ce,
        input  dm_i_stb,
        input  dm_i_we,
        input  dm_i_addr,
        input  dm_i_wdata,
        input  dm_i_sel,
        output dm_o_ack,
        output dm_o_err,
        output dm_o_rdata,
        output dm_o_stall
    );

endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory with byte lanes, ack/err response and stall.
// Ports: dm_clk, dm_rst (async active-low), bus (dmem_responder_if.slave).
module dmem_responder #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              dm_clk,
    input  logic              dm_rst,
    dmem_responder_if.slave   bus
);

    localparam int NLANE  = DWIDTH / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  ack_q;
    logic                  err_q;
    logic [DWIDTH-1:0]     rdata_q;

    logic                  accept;
    logic                  exec;
    logic                  addr_bad;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] widx;

    logic [DWIDTH-1:0]     mem [DEPTH];

    assign accept = (state == S_IDLE) & bus.dm_i_ce & bus.dm_i_stb;

    // Misaligned, or any address bit above the array span set.
    assign addr_bad = (|bus.dm_i_addr[1:0])
                    | (|(bus.dm_i_addr >> (DEPTH_LOG2 + 2)));

    assign widx = bus.dm_i_addr[DEPTH_LOG2+1:2];

    // Execute edge: the accept edge itself for zero latency, else the
    // WAIT edge where the counter has run out. Gated by reset so a
    // request caught by reset never touches the array.
    always_comb begin
        exec = 1'b0;
        if (LATENCY == 0)
            exec = accept;
        else
            exec = (state == S_WAIT) && (cnt == 4'd0);
        exec = exec & dm_rst;
    end

    assign wr_en = exec & bus.dm_i_we & ~addr_bad;

    // Array is deliberately not reset.
    always_ff @(posedge dm_clk) begin
        if (wr_en) begin
            for (int i = 0; i < NLANE; i++) begin
                if (bus.dm_i_sel[i])
                    mem[widx][8*i +: 8] <= bus.dm_i_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge dm_clk or negedge dm_rst) begin
        if (!dm_rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (LATENCY == 0) begin
                            state <= S_ACK;
                        end else begin
                            cnt   <= LAT_M1[3:0];
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0)
                        state <= S_ACK;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // exec always leads into ACK, which lasts one cycle, so the
            // ack register is a single-cycle pulse by construction.
            ack_q <= exec;
            err_q <= exec & addr_bad;
            if (exec && !bus.dm_i_we && !addr_bad)
                rdata_q <= mem[widx];
        end
    end

    assign bus.dm_o_ack   = ack_q;
    assign bus.dm_o_err   = err_q;
    assign bus.dm_o_rdata = rdata_q;
    assign bus.dm_o_stall = bus.dm_i_stb & ~ack_q;

`ifndef SYNTHESIS
    a_ack_pulse: assert property (
        @(posedge dm_clk) disable iff (!dm_rst) ack_q |=> !ack_q);
    a_err_ack: assert property (
        @(posedge dm_clk) disable iff (!dm_rst) err_q |-> ack_q);
    a_state_ok: assert property (
        @(posedge dm_clk) disable iff (!dm_rst) state != 2'd3);
    a_ack_state: assert property (
        @(posedge dm_clk) disable iff (!dm_rst) ack_q |-> state == S_ACK);
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MEM stage of the MIPS pipeline: it accepts load/store requests from the datapath's memory stage, waits a programmable number of cycles, performs the word or byte-lane access on an internal array, and returns a one-cycle acknowledge. While a request is outstanding it drives a stall toward the pipeline, so the pipeline can be tested against realistic non-zero-latency memory.

## Interface

- DWIDTH, 32, data word width; must be a multiple of 8.
- AWIDTH, 32, byte-address width.
- DEPTH_LOG2, 10, log2 of the word count; the array holds 2^DEPTH_LOG2 words.
- LATENCY, 2, wait cycles between accept and acknowledge; 0 to 15.
- dm_clk  input  1  clock; all state changes on the rising edge.
- dm_rst  input  1  asynchronous, active-low reset.
- dm_i_ce  input  1  enable; gates acceptance of new requests only.
- dm_i_stb  input  1  request valid; held with its fields until dm_o_ack.
- dm_i_we  input  1  1 = store, 0 = load.
- dm_i_addr  input  AWIDTH  byte address.
- dm_i_wdata  input  DWIDTH  store data.
- dm_i_sel  input  DWIDTH/8  byte-lane enables; sel[i] covers bits 8i+7:8i.
- dm_o_ack  output  1  one-cycle completion pulse, registered.
- dm_o_err  output  1  valid with ack; the request was rejected.
- dm_o_rdata  output  DWIDTH  load data, registered; valid in the ack cycle.
- dm_o_stall  output  1  combinational: dm_i_stb & ~dm_o_ack.

## Operation

- The FSM has three states: IDLE, WAIT and ACK.
- **IDLE:** a request is accepted at a rising edge when dm_i_ce and dm_i_stb are both 1.
  - LATENCY > 0: the counter loads LATENCY-1 and the FSM goes to WAIT.
  - LATENCY = 0: the access executes and the FSM goes directly to ACK.
- **WAIT:** the counter decrements each edge. At the edge where the counter is 0, the access executes, dm_o_ack is set to 1, and the FSM goes to ACK.
- **ACK:** dm_o_ack = 1 for exactly one cycle. The next edge clears ack/err and returns the FSM to IDLE.
  - A dm_i_stb still high in the following IDLE cycle is a new request.
- **Access rules:**
  - The word index is dm_i_addr[DEPTH_LOG2+1:2].
  - Store: each lane with sel[i]=1 is written; other lanes are unchanged. dm_o_rdata is unchanged on a store.
  - Load: the full word goes to dm_o_rdata. sel is ignored.
- **Error case:** dm_o_err = 1 with ack if dm_i_addr[1:0] != 0, or if any bit of dm_i_addr[AWIDTH-1:DEPTH_LOG2+2] is 1.
  - The array is not accessed and dm_o_rdata holds its previous value.
  - The error check uses the address sampled at the execute edge.
- **Enable:** dm_i_ce = 0 blocks acceptance only. An in-flight request still completes.
- **Array contents:** not reset and undefined at power-up. Benches write a location before reading it.

## Timing

- **Reset (dm_rst=0), asynchronous:**
  - FSM goes to IDLE and the counter to 0.
  - dm_o_ack=0, dm_o_err=0, dm_o_rdata=0.
  - dm_o_stall follows dm_i_stb.
- **Reset mid-request:** the request is abandoned with no ack, and a pending store is not written. A stb still held after reset release is accepted as a new request.
- **Latency:** with the accept at edge N, the ack is high during the cycle after edge N+LATENCY. The requester therefore sees stall high for LATENCY+1 cycles, then ack.
- **Back-to-back requests:** minimum spacing from one accept to the next is LATENCY+2 edges; there is one IDLE cycle after each ack.
- **Ack cycle:** stall is 0, so the pipeline advances at the end of that cycle and captures dm_o_rdata.
- Requester fields that change while stall is high are a protocol violation; the resulting behaviour is undefined.

## Test plan

- **Reset values.** Hold dm_rst=0 for 2 cycles with stb=0 -> ack=0, err=0, rdata=0, stall=0. Assert reset asynchronously mid-cycle -> outputs clear before the next edge.
- **Store then load, LATENCY=2.**
  - Store 0xDEADBEEF to 0x10 with sel=4'hF -> ack high in the 3rd cycle after the accept edge; stall high for the 3 cycles before it.
  - Then load 0x10 -> rdata=0xDEADBEEF with ack, err=0.
- **Byte-lane store.** Store wdata=0x0000AA00 with sel=4'b0010 to 0x10, then load 0x10 -> 0xDEADAAEF.
- **Error cases.** Each case below -> ack with err=1, and rdata stays 0xDEADAAEF:
  - load 0x13 (misaligned);
  - store 0x1000 (out of range) — a subsequent load of 0x0 returns its previously written value.
- **Enable gating.** stb=1 with ce=0 for 5 cycles -> no ack, stall=1 throughout. Raise ce -> accepted at the next edge, ack LATENCY+1 cycles later. Drop ce during WAIT -> ack still arrives.
- **Reset during WAIT.** Load 0x20 (holding 0x11111111), then start a store of 0x22222222 to 0x20 and pulse dm_rst=0 in its WAIT -> no ack. After release, a load of 0x20 returns 0x11111111. Also run this scenario with LATENCY=0: ack arrives 1 cycle after accept.
